btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter NBTN, default 2: number of button channels (1..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000: number of consecutive synchronized cycles a changed level must hold before it is accepted (2..65535).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1'b0: when 1, the raw pin is inverted before synchronization.
REQ-004 SHALL have ports:
  i_clk       input   1     system clock; one clock domain
  i_reset     input   1     reset, asynchronous, active-high
  i_btn_raw   input   NBTN  raw button pins, asynchronous to i_clk
  o_btn       output  NBTN  debounced, active-high level; feeds the button inputs of the peripheral I/O register
  o_press     output  NBTN  one-cycle pulse on an accepted 0->1 transition
  o_release   output  NBTN  one-cycle pulse on an accepted 1->0 transition
  o_any_press output  1     OR-reduction of o_press (interrupt source)

Function
REQ-005 Each channel SHALL pass its (optionally inverted) raw input through a two-flop synchronizer; the second flop output is the sample "s".
REQ-006 Each channel SHALL run a two-state FSM with states STABLE and COUNTING, a counter CNT of width clog2(DEBOUNCE_CYCLES+1), and an accepted level L driving o_btn.
REQ-007 In STABLE with s==L: hold; CNT=0.
REQ-008 In STABLE with s!=L: go to COUNTING; CNT<=1.
REQ-009 In COUNTING with s==L: return to STABLE; CNT<=0; no pulse. This rejects glitches shorter than DEBOUNCE_CYCLES.
REQ-010 In COUNTING with s!=L and CNT<DEBOUNCE_CYCLES: CNT<=CNT+1.
REQ-011 In COUNTING with s!=L and CNT==DEBOUNCE_CYCLES: L<=s; CNT<=0; go to STABLE; o_press (if s=1) or o_release (if s=0) asserted for exactly that one following cycle.
REQ-012 Latency: a clean raw edge SHALL appear on o_btn exactly DEBOUNCE_CYCLES+2 rising clock edges after the first edge at which the raw level is sampled changed, with the press/release pulse coincident with the o_btn change.
REQ-013 o_press and o_release for a channel SHALL never be asserted in the same cycle; pulses SHALL never exceed one cycle.
REQ-014 CNT SHALL never exceed DEBOUNCE_CYCLES and SHALL never wrap.
REQ-015 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce simultaneous pulses.
REQ-016 o_press, o_release, o_btn and o_any_press SHALL all be registered outputs.

Reset
REQ-017 On i_reset high, all of the following SHALL clear immediately, without waiting for i_clk: synchronizer flops to the inactive level (logic 0 after inversion), L/o_btn=0, CNT=0, FSM=STABLE, o_press=o_release=o_any_press=0.
REQ-018 If i_reset asserts mid-count, the partial count SHALL be discarded.
REQ-019 If a button is held through reset release, the block SHALL report it as a fresh press after DEBOUNCE_CYCLES+2 cycles.

Structure
REQ-020 The shared package SHALL hold the FSM state encodings (STABLE=1'b0, COUNTING=1'b1) and the counter-width function.
REQ-021 One sub-module, btn_debounce_chan, SHALL implement a single channel (synchronizer, FSM, counter, pulses); the top level SHALL instantiate NBTN copies in a generate loop and OR the press pulses.

Verification (bench uses DEBOUNCE_CYCLES=4, NBTN=2, ACTIVE_LOW=0)
REQ-022 Clean press: raw[0] goes 0->1 and holds -> o_btn[0]=1 and o_press[0]=1 for one cycle exactly 6 edges later; o_release=0 throughout.
REQ-023 Glitch: raw[0] high for 3 cycles, then low -> o_btn, o_press and o_release stay 0; CNT returns to 0.
REQ-024 Bounce: raw toggles 1,0,1,0,1 on successive cycles, then holds 1 -> a single o_press, 6 edges after the final 0->1.
REQ-025 Release and simultaneity: both channels pressed, then both released on the same cycle -> o_release=2'b11 in one cycle and o_any_press=0 in that cycle.
REQ-026 Reset mid-count: assert i_reset asynchronously 2 cycles into a count -> all outputs 0 immediately; with raw held high, o_press fires 6 edges after reset release.
REQ-027 ACTIVE_LOW=1 build: raw 1->0 -> o_btn 0->1 with o_press after 6 edges.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared FSM encodings and counter sizing for the button debouncer
package btn_debounce_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  function automatic int cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - button pins in, debounced levels and edge pulses out
interface btn_debounce_if #(
  parameter int NBTN = 2
);
  logic [NBTN-1:0] i_btn_raw;
  logic [NBTN-1:0] o_btn;
  logic [NBTN-1:0] o_press;
  logic [NBTN-1:0] o_release;
  logic            o_any_press;

  modport master (
    output i_btn_raw,
    input  o_btn, o_press, o_release, o_any_press
  );

  modport slave (
    input  i_btn_raw,
    output o_btn, o_press, o_release, o_any_press
  );
endinterface

// File: rtl/btn_debounce_chan.sv
// rtl/btn_debounce_chan.sv - one debounce channel: 2-flop synchronizer, hold-time FSM, edge pulses
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic        ACTIVE_LOW      = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_btn,
  output logic o_press,
  output logic o_release,
  output logic o_press_next
);
  localparam int            CW      = cnt_width(int'(DEBOUNCE_CYCLES));
  localparam logic [CW-1:0] CNT_MAX = DEBOUNCE_CYCLES[CW-1:0];

  logic          sync1;
  logic          s;
  state_e        state;
  logic [CW-1:0] cnt;
  logic          accept;

  // The new level is taken on the (DEBOUNCE_CYCLES+1)-th consecutive differing sample.
  assign accept       = (state == ST_COUNTING) && (s != o_btn) && (cnt == CNT_MAX);
  assign o_press_next = accept && s;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1     <= 1'b0;
      s         <= 1'b0;
      state     <= ST_STABLE;
      cnt       <= '0;
      o_btn     <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      sync1     <= i_raw ^ ACTIVE_LOW;
      s         <= sync1;
      o_press   <= accept && s;
      o_release <= accept && !s;
      case (state)
        ST_STABLE: begin
          if (s != o_btn) begin
            state <= ST_COUNTING;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        ST_COUNTING: begin
          if (s == o_btn) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (accept) begin
            o_btn <= s;
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - NBTN independent debounce channels with a combined press interrupt
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int          NBTN            = 2,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic        ACTIVE_LOW      = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_reset,
  btn_debounce_if.slave  bus
);
  logic [NBTN-1:0] btn_w;
  logic [NBTN-1:0] press_w;
  logic [NBTN-1:0] release_w;
  logic [NBTN-1:0] press_next_w;
  logic            any_press_q;

  for (genvar g = 0; g < NBTN; g++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_raw       (bus.i_btn_raw[g]),
      .o_btn       (btn_w[g]),
      .o_press     (press_w[g]),
      .o_release   (release_w[g]),
      .o_press_next(press_next_w[g])
    );
  end

  // Registered from the channels' next-cycle press so it lines up with o_press.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_next_w;
    end
  end

  assign bus.o_btn       = btn_w;
  assign bus.o_press     = press_w;
  assign bus.o_release   = release_w;
  assign bus.o_any_press = any_press_q;

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - self-checking bench for btn_debounce
module tb_btn_debounce;
  localparam int NBTN = 2;
  localparam int DC   = 4;

  typedef struct {
    logic [1:0] raw;
    int         hold;
    logic [1:0] exp_btn;
    logic [1:0] exp_press;
    logic [1:0] exp_rel;
    logic       exp_any;
  } vec_t;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  bit   chk_en  = 1'b0;
  int   press_cnt0 = 0;

  btn_debounce_if #(.NBTN(NBTN)) bus ();
  btn_debounce_if #(.NBTN(1))    bus_al ();

  btn_debounce #(.NBTN(NBTN), .DEBOUNCE_CYCLES(16'(DC)), .ACTIVE_LOW(1'b0)) u_dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  btn_debounce #(.NBTN(1), .DEBOUNCE_CYCLES(16'(DC)), .ACTIVE_LOW(1'b1)) u_dut_al (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus_al)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the level seen by the decision logic is the raw pin two clocks late;
  // a channel adopts a new level once it has disagreed for DC+1 consecutive clocks.
  logic [NBTN-1:0] rawq[$];
  logic [NBTN-1:0] m_btn   = '0;
  logic [NBTN-1:0] m_press = '0;
  logic [NBTN-1:0] m_rel   = '0;
  int              run[NBTN];

  always @(posedge i_clk or posedge i_reset) begin : mdl
    logic [NBTN-1:0] s;
    if (i_reset) begin
      rawq.delete();
      m_btn   = '0;
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < NBTN; c++) run[c] = 0;
    end else begin
      s = (rawq.size() >= 2) ? rawq[rawq.size()-2] : '0;
      rawq.push_back(bus.i_btn_raw);
      if (rawq.size() > 4) void'(rawq.pop_front());
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < NBTN; c++) begin
        if (s[c] != m_btn[c]) begin
          run[c]++;
          if (run[c] == DC + 1) begin
            m_btn[c]   = s[c];
            m_press[c] = s[c];
            m_rel[c]   = ~s[c];
            run[c]     = 0;
          end
        end else begin
          run[c] = 0;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("model_btn",       32'(bus.o_btn),       32'(m_btn));
      check("model_press",     32'(bus.o_press),     32'(m_press));
      check("model_release",   32'(bus.o_release),   32'(m_rel));
      check("model_any_press", 32'(bus.o_any_press), 32'(|m_press));
      if (bus.o_press[0]) press_cnt0++;
    end
  end

  // Counts clock edges after the one that first samples the new raw level.
  task automatic measure_press(input bit al, input int ch, output int n);
    n = -1;
    @(posedge i_clk);
    for (int k = 1; k <= 20; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (al ? bus_al.o_press[0] : bus.o_press[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  vec_t tbl[10];
  int   n;
  int   pc;

  initial begin
    bus.i_btn_raw    = '0;
    bus_al.i_btn_raw = 1'b1;

    tbl[0] = '{2'b00, 10, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[1] = '{2'b01,  4, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[2] = '{2'b00, 10, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[3] = '{2'b01,  5, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[4] = '{2'b00, 10, 2'b00, 2'b01, 2'b01, 1'b1};
    tbl[5] = '{2'b11, 10, 2'b11, 2'b11, 2'b00, 1'b1};
    tbl[6] = '{2'b00, 10, 2'b00, 2'b00, 2'b11, 1'b0};
    tbl[7] = '{2'b10,  7, 2'b10, 2'b10, 2'b00, 1'b1};
    tbl[8] = '{2'b00,  6, 2'b10, 2'b00, 2'b00, 1'b0};
    tbl[9] = '{2'b00,  1, 2'b00, 2'b00, 2'b10, 1'b0};

    repeat (3) @(negedge i_clk);
    check("reset_outputs", {28'd0, bus.o_btn, bus.o_press}, 32'd0);
    check("reset_release_any", {29'd0, bus.o_release, bus.o_any_press}, 32'd0);
    check("reset_al_btn", 32'(bus_al.o_btn), 32'd0);
    i_reset = 1'b0;
    chk_en  = 1'b1;

    for (int i = 0; i < 10; i++) begin
      logic [1:0] ps, rs;
      logic       an;
      bus.i_btn_raw = tbl[i].raw;
      ps = '0; rs = '0; an = 1'b0;
      for (int k = 0; k < tbl[i].hold; k++) begin
        @(posedge i_clk);
        @(negedge i_clk);
        ps |= bus.o_press;
        rs |= bus.o_release;
        an |= bus.o_any_press;
      end
      check($sformatf("vec%0d_btn", i),     32'(bus.o_btn), 32'(tbl[i].exp_btn));
      check($sformatf("vec%0d_press", i),   32'(ps),        32'(tbl[i].exp_press));
      check($sformatf("vec%0d_release", i), 32'(rs),        32'(tbl[i].exp_rel));
      check($sformatf("vec%0d_any", i),     32'(an),        32'(tbl[i].exp_any));
    end

    // Bounce on channel 0 ending high.
    pc = press_cnt0;
    bus.i_btn_raw[0] = 1'b1; @(negedge i_clk);
    bus.i_btn_raw[0] = 1'b0; @(negedge i_clk);
    bus.i_btn_raw[0] = 1'b1; @(negedge i_clk);
    bus.i_btn_raw[0] = 1'b0; @(negedge i_clk);
    bus.i_btn_raw[0] = 1'b1;
    measure_press(1'b0, 0, n);
    check("bounce_latency", 32'(n), 32'(DC + 2));
    repeat (10) @(negedge i_clk);
    check("bounce_single_press", 32'(press_cnt0 - pc), 32'd1);
    bus.i_btn_raw = 2'b00;
    repeat (12) @(negedge i_clk);

    // Asynchronous reset two counts into a release of channel 1.
    bus.i_btn_raw = 2'b11;
    repeat (10) @(negedge i_clk);
    check("pre_reset_btn", 32'(bus.o_btn), 32'h3);
    bus.i_btn_raw = 2'b01;
    @(posedge i_clk);
    repeat (3) @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    check("async_reset_btn", 32'(bus.o_btn), 32'd0);
    check("async_reset_pulses", {29'd0, bus.o_press[0], bus.o_release[0], bus.o_any_press}, 32'd0);
    @(negedge i_clk);
    bus.i_btn_raw = 2'b11;
    @(negedge i_clk);
    i_reset = 1'b0;
    measure_press(1'b0, 0, n);
    check("held_through_reset_latency", 32'(n), 32'(DC + 2));
    check("held_through_reset_both", 32'(bus.o_press), 32'h3);

    // Inverted-pin build.
    check("al_idle_btn", 32'(bus_al.o_btn), 32'd0);
    bus_al.i_btn_raw = 1'b0;
    measure_press(1'b1, 0, n);
    check("al_press_latency", 32'(n), 32'(DC + 2));
    check("al_btn_high", 32'(bus_al.o_btn), 32'd1);

    // Random toggling against the reference model.
    repeat (400) begin
      @(negedge i_clk);
      for (int c = 0; c < NBTN; c++) begin
        if ($urandom_range(0, 4) == 0) bus.i_btn_raw[c] = ~bus.i_btn_raw[c];
      end
    end
    repeat (12) @(negedge i_clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
